// File: rtl/raisin64_mem_pkg.sv
// Shared definitions for the raisin64 memory controllers: width codes, FSM
// state encoding and request-owner type.
package raisin64_mem_pkg;

  localparam logic [1:0] WW_64 = 2'd0;
  localparam logic [1:0] WW_32 = 2'd1;
  localparam logic [1:0] WW_16 = 2'd2;
  localparam logic [1:0] WW_8  = 2'd3;

  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t ACCESS = 2'd1;
  localparam state_t DONE   = 2'd2;

  typedef enum logic {OWN_CPU, OWN_DBG} owner_t;

  function automatic logic [3:0] width_bytes(input logic [1:0] code);
    case (code)
      WW_64:   return 4'd8;
      WW_32:   return 4'd4;
      WW_16:   return 4'd2;
      default: return 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_addr_check.sv
// Combinational alignment and range check for a byte address and width code.
module dmem_addr_check
  import raisin64_mem_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int NUM_BYTES = 256
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        width,
  output logic              misaligned,
  output logic              out_of_range
);

  logic [ADDR_W-1:0] align_mask;

  // NOTE: every output of a combinational block is assigned on every path,
  // so no latch can be inferred.
  always_comb begin
    align_mask   = ADDR_W'(width_bytes(width)) - ADDR_W'(1);
    misaligned   = |(addr & align_mask);
    out_of_range = addr >= ADDR_W'(NUM_BYTES);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory access controller: arbitrates pipeline and debug requests onto a
// synchronous single-port RAM with configurable wait states and bus errors.
module dmem_arbiter
  import raisin64_mem_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int NUM_BYTES   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              cpu_rst_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [1:0]        cpu_write_width,
  input  logic              cpu_rstrobe,
  input  logic              cpu_wstrobe,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_cycle_complete,
  output logic              cpu_bus_error,
  input  logic              dbg_halt,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_ce,
  input  logic              dbg_we,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ready,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [1:0]        ram_write_width,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [3:0] LAST_WAIT = 4'(WAIT_STATES);

  state_t            state;
  owner_t            owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        width_q;
  logic              we_q;
  logic              err_q;
  logic [3:0]        wait_cnt;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_q;

  logic              req;
  logic [ADDR_W-1:0] sel_addr;
  logic [1:0]        sel_width;
  logic              misaligned;
  logic              out_of_range;
  logic [DATA_W-1:0] rdata_now;

  // While halted only the debug port may start an access; otherwise only the CPU.
  always_comb begin
    req       = dbg_halt ? dbg_ce : (cpu_rstrobe | cpu_wstrobe);
    sel_addr  = dbg_halt ? dbg_addr : cpu_addr;
    sel_width = dbg_halt ? WW_64 : cpu_write_width;
    rdata_now = err_q ? '0 : ram_rdata;
  end

  dmem_addr_check #(
    .ADDR_W    (ADDR_W),
    .NUM_BYTES (NUM_BYTES)
  ) u_addr_check (
    .addr         (sel_addr),
    .width        (sel_width),
    .misaligned   (misaligned),
    .out_of_range (out_of_range)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state       <= IDLE;
      owner_q     <= OWN_CPU;
      addr_q      <= '0;
      wdata_q     <= '0;
      width_q     <= '0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      wait_cnt    <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          addr_q   <= sel_addr;
          width_q  <= sel_width;
          owner_q  <= dbg_halt ? OWN_DBG : OWN_CPU;
          wdata_q  <= dbg_halt ? dbg_wdata : cpu_wdata;
          we_q     <= dbg_halt ? dbg_we : cpu_wstrobe;
          err_q    <= misaligned | out_of_range;
          wait_cnt <= '0;
          state    <= (misaligned | out_of_range) ? DONE : ACCESS;
        end
        ACCESS: begin
          if (wait_cnt == LAST_WAIT) state <= DONE;
          else wait_cnt <= wait_cnt + 4'd1;
        end
        DONE: begin
          // Keep the delivered data visible until the owner's next completion.
          if (owner_q == OWN_CPU) cpu_rdata_q <= rdata_now;
          else dbg_rdata_q <= rdata_now;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ram_cs             = (state == ACCESS);
  assign ram_we             = ram_cs & we_q;
  assign ram_write_width    = ram_cs ? width_q : '0;
  assign ram_addr           = ram_cs ? addr_q : '0;
  assign ram_wdata          = ram_cs ? wdata_q : '0;

  assign cpu_cycle_complete = (state == DONE) && (owner_q == OWN_CPU);
  assign dbg_ready          = (state == DONE) && (owner_q == OWN_DBG);
  assign cpu_bus_error      = cpu_cycle_complete & err_q;
  assign cpu_rdata          = cpu_cycle_complete ? rdata_now : cpu_rdata_q;
  assign dbg_rdata          = dbg_ready ? rdata_now : dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised self-checking bench for dmem_arbiter against a byte-array memory
// model and transaction-level latency rules.
module tb_dmem_arbiter;
  import raisin64_mem_pkg::*;

  localparam int ADDR_W    = 64;
  localparam int DATA_W    = 64;
  localparam int NUM_BYTES = 256;
  localparam int WS        = 2;

  logic              clk = 1'b0;
  logic              cpu_rst_n;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [1:0]        cpu_write_width;
  logic              cpu_rstrobe, cpu_wstrobe;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_cycle_complete, cpu_bus_error;
  logic              dbg_halt;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ce, dbg_we;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ready;
  logic              ram_cs, ram_we;
  logic [1:0]        ram_write_width;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_BYTES(NUM_BYTES), .WAIT_STATES(WS)
  ) dut (
    .clk(clk), .cpu_rst_n(cpu_rst_n),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_write_width(cpu_write_width),
    .cpu_rstrobe(cpu_rstrobe), .cpu_wstrobe(cpu_wstrobe),
    .cpu_rdata(cpu_rdata), .cpu_cycle_complete(cpu_cycle_complete),
    .cpu_bus_error(cpu_bus_error),
    .dbg_halt(dbg_halt), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ce(dbg_ce), .dbg_we(dbg_we), .dbg_rdata(dbg_rdata), .dbg_ready(dbg_ready),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_write_width(ram_write_width),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // External synchronous RAM: byte writes of the forwarded width, 8-byte reads
  // starting at the addressed byte, data registered one cycle after cs.
  logic [7:0] ram_mem [NUM_BYTES];
  logic [7:0] ref_mem [NUM_BYTES];

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        for (int i = 0; i < int'(width_bytes(ram_write_width)); i++)
          ram_mem[8'(ram_addr[7:0] + 8'(i))] = ram_wdata[8*i +: 8];
      end else begin
        for (int i = 0; i < 8; i++)
          ram_rdata[8*i +: 8] <= ram_mem[8'(ram_addr[7:0] + 8'(i))];
      end
    end
  end

  int total = 0;
  int bad   = 0;
  int cpu_pulses = 0, dbg_pulses = 0, stray_err = 0;

  always @(negedge clk) begin
    if (cpu_cycle_complete) cpu_pulses++;
    if (dbg_ready) dbg_pulses++;
    if (cpu_bus_error && !cpu_cycle_complete) stray_err++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_word(input logic [7:0] a);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = ref_mem[8'(a + 8'(i))];
    return w;
  endfunction

  task automatic drop_all();
    cpu_rstrobe = 1'b0; cpu_wstrobe = 1'b0; dbg_ce = 1'b0; dbg_we = 1'b0;
  endtask

  // One request; completion expected WS+2 cycles after acceptance, or next cycle on error.
  task automatic run_txn(input bit dbg, input bit wr, input logic [63:0] addr,
                         input logic [1:0] width, input logic [63:0] data, input string tag);
    int wb, lat, cs_cycles, exp_lat;
    bit err, done, other, ram_bad;
    logic [63:0] exp_rd, got_rd;
    logic got_err;
    wb      = dbg ? 8 : int'(width_bytes(width));
    err     = ((addr % 64'(wb)) != 0) || (addr >= 64'(NUM_BYTES));
    exp_rd  = err ? 64'd0 : ref_word(addr[7:0]);
    exp_lat = err ? 1 : WS + 2;
    @(negedge clk);
    dbg_halt = dbg;
    if (dbg) begin
      dbg_ce = 1'b1; dbg_we = wr; dbg_addr = addr; dbg_wdata = data;
      cpu_rstrobe = 1'($urandom_range(0, 1));
      cpu_addr = 64'($urandom_range(0, 255));
    end else begin
      cpu_wstrobe = wr;
      cpu_rstrobe = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      cpu_addr = addr; cpu_write_width = width; cpu_wdata = data;
      dbg_ce = 1'($urandom_range(0, 1)); dbg_we = 1'($urandom_range(0, 1));
      dbg_addr = 64'($urandom_range(0, 255));
    end
    lat = 0; cs_cycles = 0; done = 0; other = 0; ram_bad = 0;
    got_rd = '0; got_err = 1'b0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (ram_cs) begin
        cs_cycles++;
        if (ram_addr !== addr || ram_we !== wr || ram_write_width !== (dbg ? WW_64 : width) ||
            (wr && ram_wdata !== data)) ram_bad = 1;
      end
      if (dbg ? cpu_cycle_complete : dbg_ready) other = 1;
      if (dbg ? dbg_ready : cpu_cycle_complete) begin
        done = 1; got_rd = dbg ? dbg_rdata : cpu_rdata; got_err = cpu_bus_error;
      end
    end
    drop_all();
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_cs_cycles"}, 64'(cs_cycles), err ? 64'd0 : 64'(WS + 1));
    check({tag, "_ram_bus"}, 64'(ram_bad), 64'd0);
    check({tag, "_wrong_port"}, 64'(other), 64'd0);
    check({tag, "_bus_error"}, 64'(got_err), (dbg || !err) ? 64'd0 : 64'd1);
    if (!wr || err) check({tag, "_rdata"}, got_rd, exp_rd);
    if (wr && !err)
      for (int i = 0; i < wb; i++) ref_mem[8'(addr[7:0] + 8'(i))] = data[8*i +: 8];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [63:0] exp_w, a, d;
    int cyc, cpu_cyc, dbg_cyc, cpu_n, dbg_n, c1, c2, snap;
    logic [1:0] w;
    bit dbg, wr;

    cpu_rst_n = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; cpu_write_width = '0;
    dbg_halt = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    drop_all();
    for (int i = 0; i < NUM_BYTES; i++) begin
      ram_mem[i] = 8'($urandom);
      ref_mem[i] = ram_mem[i];
    end
    exp_w = 64'hDEADBEEF_CAFEF00D;
    for (int i = 0; i < 8; i++) begin
      ram_mem[16 + i] = exp_w[8*i +: 8];
      ref_mem[16 + i] = exp_w[8*i +: 8];
    end

    #1;
    check("reset_ctl", 64'({ram_cs, ram_we, ram_write_width, cpu_cycle_complete,
                            cpu_bus_error, dbg_ready}), 64'd0);
    check("reset_cpu_rdata", cpu_rdata, 64'd0);
    check("reset_dbg_rdata", dbg_rdata, 64'd0);
    check("reset_ram_addr", ram_addr, 64'd0);
    repeat (2) @(negedge clk);
    cpu_rst_n = 1'b1;

    run_txn(0, 0, 64'h10, WW_64, 64'd0, "rd_0x10");
    run_txn(0, 1, 64'h21, WW_8, 64'hAB, "wr_byte_0x21");
    run_txn(0, 0, 64'h21, WW_8, 64'd0, "rd_byte_0x21");
    check("rd_byte_0x21_ram_low", 64'(ram_rdata[7:0]), 64'hAB);
    run_txn(0, 0, 64'h06, WW_32, 64'd0, "misaligned_32");
    run_txn(0, 1, 64'h100, WW_64, 64'h1234, "out_of_range");
    run_txn(0, 0, 64'h8000_0000_0000_0010, WW_64, 64'd0, "out_of_range_high");
    run_txn(0, 0, 64'hFF, WW_8, 64'd0, "last_byte");
    run_txn(1, 0, 64'h0C, WW_64, 64'd0, "dbg_misaligned");
    run_txn(0, 0, 64'hF8, WW_64, 64'd0, "last_word");

    // Halt rising during a CPU read: CPU finishes first, then the debug write.
    d = {$urandom, $urandom};
    exp_w = ref_word(8'h40);
    @(negedge clk);
    dbg_halt = 1'b0; cpu_rstrobe = 1'b1; cpu_addr = 64'h40; cpu_write_width = WW_64;
    @(negedge clk);
    dbg_halt = 1'b1; dbg_ce = 1'b1; dbg_we = 1'b1; dbg_addr = 64'h08; dbg_wdata = d;
    cpu_cyc = 0; dbg_cyc = 0; cpu_n = 0; dbg_n = 0;
    for (cyc = 2; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (cpu_cycle_complete) begin
        cpu_n++;
        if (cpu_n == 1) begin
          cpu_cyc = cyc;
          check("halt_cpu_rdata", cpu_rdata, exp_w);
        end
      end
      if (dbg_ready) begin
        dbg_n++;
        if (dbg_n == 1) dbg_cyc = cyc;
        dbg_ce = 1'b0; dbg_we = 1'b0;
      end
    end
    check("halt_cpu_cycle", 64'(cpu_cyc), 64'(WS + 2));
    check("halt_cpu_pulses", 64'(cpu_n), 64'd1);
    check("halt_dbg_cycle", 64'(dbg_cyc), 64'(2 * WS + 5));
    check("halt_dbg_pulses", 64'(dbg_n), 64'd1);
    for (int i = 0; i < 8; i++) ref_mem[8 + i] = d[8*i +: 8];
    drop_all();
    dbg_halt = 1'b0;
    run_txn(1, 0, 64'h08, WW_64, 64'd0, "dbg_readback");

    // Strobe held through DONE: next acceptance only in the following IDLE cycle.
    exp_w = ref_word(8'h18);
    @(negedge clk);
    dbg_halt = 1'b0; cpu_rstrobe = 1'b1; cpu_addr = 64'h18; cpu_write_width = WW_64;
    c1 = 0; c2 = 0;
    for (cyc = 1; cyc <= 30 && c2 == 0; cyc++) begin
      @(negedge clk);
      if (cpu_cycle_complete) begin
        if (c1 == 0) c1 = cyc; else c2 = cyc;
        check("b2b_rdata", cpu_rdata, exp_w);
      end
    end
    drop_all();
    check("b2b_first", 64'(c1), 64'(WS + 2));
    check("b2b_period", 64'(c2 - c1), 64'(WS + 3));

    // Reset in the middle of an access drops it silently.
    @(negedge clk);
    cpu_rstrobe = 1'b1; cpu_addr = 64'h20; cpu_write_width = WW_64;
    @(negedge clk);
    @(negedge clk);
    check("midrst_in_access", 64'(ram_cs), 64'd1);
    cpu_rst_n = 1'b0;
    #1;
    check("midrst_ctl", 64'({ram_cs, ram_we, ram_write_width, cpu_cycle_complete,
                             cpu_bus_error, dbg_ready}), 64'd0);
    check("midrst_cpu_rdata", cpu_rdata, 64'd0);
    check("midrst_ram_wdata", ram_wdata, 64'd0);
    drop_all();
    snap = cpu_pulses + dbg_pulses;
    @(negedge clk);
    cpu_rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst_no_pulse", 64'(cpu_pulses + dbg_pulses - snap), 64'd0);
    run_txn(0, 0, 64'h20, WW_64, 64'd0, "after_reset");

    for (int n = 0; n < 150; n++) begin
      dbg = ($urandom_range(0, 3) == 0);
      wr  = 1'($urandom_range(0, 1));
      w   = 2'($urandom_range(0, 3));
      a   = 64'($urandom_range(0, 'h11F));
      if ($urandom_range(0, 3) != 0) a = a & ~(64'(dbg ? 8 : int'(width_bytes(w))) - 64'd1);
      if ($urandom_range(0, 15) == 0) a = a | 64'h0000_0100_0000_0000;
      d = {$urandom, $urandom};
      run_txn(dbg, wr, a, w, d, dbg ? "rand_dbg" : "rand_cpu");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    check("stray_bus_error", 64'(stray_err), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
